draw_rect_ctl: RTL and testbench

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

---
 rtl/draw_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 28 ++
 rtl/draw_rect_ctl.sv | 144 ++++++++++++++
 tb/tb_draw_rect_ctl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and default geometry for the rectangle jump controller.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHARGE  = 2'd1,
    JUMP_UP = 2'd2,
    FALL    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

  localparam int DEF_TICK_CYCLES = 1_000_000;
  localparam int DEF_SCREEN_W    = 800;
  localparam int DEF_SCREEN_H    = 600;
  localparam int DEF_RECT_W      = 64;
  localparam int DEF_RECT_H      = 64;

  // Pressing both keys cancels out, same as pressing neither.
  function automatic dir_t key_dir(input logic right, input logic left);
    dir_t d;
    d = DIR_NONE;
    if (right && !left) d = DIR_RIGHT;
    if (left && !right) d = DIR_LEFT;
    return d;
  endfunction

  function automatic logic [11:0] step_x(input logic [11:0] px, input dir_t dir,
                                         input logic [12:0] step, input logic [12:0] x_max);
    logic [12:0] wide;
    wide = {1'b0, px};
    case (dir)
      DIR_RIGHT: begin
        wide = wide + step;
        if (wide > x_max) wide = x_max;
      end
      DIR_LEFT: begin
        if (wide < step) wide = 13'd0;
        else wide = wide - step;
      end
      default: wide = {1'b0, px};
    endcase
    return wide[11:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..TICK_CYCLES-1 and flags the last count as the physics tick.
module tick_gen #(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [23:0] cycle_counter_o,
  output logic        tick_o
);

  localparam logic [23:0] LAST = 24'(TICK_CYCLES - 1);

  logic [23:0] cnt_q, cnt_d;

  assign tick_o          = (cnt_q == LAST);
  assign cycle_counter_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (tick_o) cnt_d = 24'd0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) cnt_q <= 24'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle position controller: walk left/right on the ground, charge a jump with space,
// then fly with a latched direction under per-tick gravity. Outputs lag position by one clock.
module draw_rect_ctl
  import draw_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int RECT_W      = DEF_RECT_W,
  parameter int RECT_H      = DEF_RECT_H,
  parameter int X_STEP      = 2,
  parameter int V_MIN       = 4,
  parameter int MAX_CHARGE  = 31,
  parameter int MAX_FALL    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_space,
  input  logic        key_right,
  input  logic        key_left,
  output logic [11:0] value_x,
  output logic [11:0] value_y
);

  localparam logic [12:0] X_MAX     = 13'(SCREEN_W - RECT_W);
  localparam logic [11:0] X_START   = 12'((SCREEN_W - RECT_W) / 2);
  localparam logic [12:0] GROUND_Y  = 13'(SCREEN_H - RECT_H);
  localparam logic [11:0] GROUND_12 = 12'(SCREEN_H - RECT_H);
  localparam logic [12:0] STEP      = 13'(X_STEP);
  localparam logic [7:0]  VMIN8     = 8'(V_MIN);
  localparam logic [5:0]  CHG_MAX   = 6'(MAX_CHARGE);
  localparam logic [7:0]  FALL_MAX  = 8'(MAX_FALL);

  logic [23:0] cycle_counter;
  logic        tick;

  state_t      state, state_d;
  logic [11:0] position_x, position_x_d;
  logic [11:0] position_y, position_y_d;
  logic [7:0]  velocity_y, velocity_y_d;
  logic [5:0]  time_passed, time_passed_d;
  dir_t        dir_q, dir_d;

  logic        ceiling_hit;
  logic [11:0] up_diff;
  logic [7:0]  vel_dec;
  logic [7:0]  fall_v;
  logic [12:0] down_sum;
  dir_t        live_dir;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk_i           (clk),
    .rst_i           (rst),
    .cycle_counter_o (cycle_counter),
    .tick_o          (tick)
  );

  // Ceiling is judged at 13 bits so an oversized velocity can never wrap position_y.
  assign ceiling_hit = {5'b0, velocity_y} >= {1'b0, position_y};
  assign up_diff     = position_y - {4'b0, velocity_y};
  assign vel_dec     = velocity_y - 8'd1;
  assign fall_v      = (velocity_y >= FALL_MAX) ? FALL_MAX : velocity_y + 8'd1;
  assign down_sum    = {1'b0, position_y} + {5'b0, fall_v};
  assign live_dir    = key_dir(key_right, key_left);

  always_comb begin
    state_d       = state;
    position_x_d  = position_x;
    position_y_d  = position_y;
    velocity_y_d  = velocity_y;
    time_passed_d = time_passed;
    dir_d         = dir_q;
    case (state)
      IDLE: begin
        if (key_space) begin
          state_d       = CHARGE;
          time_passed_d = 6'd0;
        end else if (tick) begin
          position_x_d = step_x(position_x, live_dir, STEP, X_MAX);
        end
      end
      CHARGE: begin
        if (!key_space) begin
          state_d      = JUMP_UP;
          velocity_y_d = VMIN8 + {2'b0, time_passed};
          dir_d        = live_dir;
        end else if (tick && time_passed < CHG_MAX) begin
          time_passed_d = time_passed + 6'd1;
        end
      end
      JUMP_UP: begin
        if (tick) begin
          position_x_d = step_x(position_x, dir_q, STEP, X_MAX);
          if (ceiling_hit) begin
            position_y_d = 12'd0;
            velocity_y_d = 8'd0;
            state_d      = FALL;
          end else begin
            position_y_d = up_diff;
            velocity_y_d = vel_dec;
            if (vel_dec == 8'd0) state_d = FALL;
          end
        end
      end
      FALL: begin
        if (tick) begin
          position_x_d = step_x(position_x, dir_q, STEP, X_MAX);
          if (down_sum >= GROUND_Y) begin
            position_y_d = GROUND_12;
            velocity_y_d = 8'd0;
            state_d      = IDLE;
          end else begin
            position_y_d = down_sum[11:0];
            velocity_y_d = fall_v;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      position_x  <= X_START;
      position_y  <= GROUND_12;
      velocity_y  <= 8'd0;
      time_passed <= 6'd0;
      dir_q       <= DIR_NONE;
      value_x     <= X_START;
      value_y     <= GROUND_12;
    end else begin
      state       <= state_d;
      position_x  <= position_x_d;
      position_y  <= position_y_d;
      velocity_y  <= velocity_y_d;
      time_passed <= time_passed_d;
      dir_q       <= dir_d;
      value_x     <= position_x;
      value_y     <= position_y;
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Bench for draw_rect_ctl with a 4-cycle tick; physics reference kept as plain per-tick arithmetic.
module tb_draw_rect_ctl;
  import draw_pkg::*;

  localparam int TC   = 4;
  localparam int XMAX = 736;
  localparam int GY   = 536;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_space = 1'b0, key_right = 1'b0, key_left = 1'b0;
  logic [11:0] value_x, value_y;

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int mx, my, mv, mtp;
  bit mdr, mdl;

  draw_rect_ctl #(.TICK_CYCLES(TC)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_space (key_space),
    .key_right (key_right),
    .key_left  (key_left),
    .value_x   (value_x),
    .value_y   (value_y)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  function automatic int model_x(input int x, input bit r, input bit l);
    if (r && !l) return (x + 2 > XMAX) ? XMAX : x + 2;
    if (l && !r) return (x < 2) ? 0 : x - 2;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk);
    phase = (phase == TC - 1) ? 0 : phase + 1;
    @(negedge clk);
  endtask

  task automatic next_tick();
    bit t;
    do begin
      t = (phase == TC - 1);
      cyc();
    end while (!t);
  endtask

  task automatic do_reset();
    rst = 1'b0; key_space = 1'b0; key_right = 1'b0; key_left = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    phase = 0;
    mx = 368; my = GY; mv = 0; mtp = 0;
  endtask

  task automatic do_charge(input int n, input bit r, input bit l);
    key_right = 1'b0; key_left = 1'b0;
    next_tick();
    key_space = 1'b1;
    cyc();
    mtp = 0;
    checks++; if (dut.state !== CHARGE) begin failures++; $display("FAIL charge_enter: got %0d expected %0d", dut.state, CHARGE); end
    checks++; if (dut.time_passed !== 6'(mtp)) begin failures++; $display("FAIL charge_clear: got %0d expected %0d", dut.time_passed, mtp); end
    for (int k = 0; k < n; k++) begin
      key_right = 1'($urandom); key_left = 1'($urandom);
      next_tick();
      mtp = (mtp + 1 > 31) ? 31 : mtp + 1;
      checks++; if (dut.time_passed !== 6'(mtp)) begin failures++; $display("FAIL charge_count: got %0d expected %0d", dut.time_passed, mtp); end
      checks++; if (dut.position_x !== 12'(mx)) begin failures++; $display("FAIL charge_nomove: got %0d expected %0d", dut.position_x, mx); end
    end
    key_space = 1'b0; key_right = r; key_left = l;
    cyc();
    mv = 4 + mtp; mdr = r; mdl = l;
    checks++; if (dut.state !== JUMP_UP) begin failures++; $display("FAIL takeoff_state: got %0d expected %0d", dut.state, JUMP_UP); end
    checks++; if (dut.velocity_y !== 8'(mv)) begin failures++; $display("FAIL takeoff_vel: got %0d expected %0d", dut.velocity_y, mv); end
  endtask

  task automatic run_up(input int first_y_req, output int n);
    int prev;
    state_t es;
    n = 0;
    while (1) begin
      key_space = 1'($urandom); key_right = 1'($urandom); key_left = 1'($urandom);
      next_tick();
      prev = my;
      my = (mv >= my) ? 0 : my - mv;
      mv = (my == 0) ? 0 : mv - 1;
      mx = model_x(mx, mdr, mdl);
      n++;
      es = (mv == 0) ? FALL : JUMP_UP;
      checks++; if (dut.position_y !== 12'(my)) begin failures++; $display("FAIL up_y: got %0d expected %0d", dut.position_y, my); end
      checks++; if (dut.velocity_y !== 8'(mv)) begin failures++; $display("FAIL up_vel: got %0d expected %0d", dut.velocity_y, mv); end
      checks++; if (dut.position_x !== 12'(mx)) begin failures++; $display("FAIL up_x: got %0d expected %0d", dut.position_x, mx); end
      checks++; if (value_y !== 12'(prev)) begin failures++; $display("FAIL up_value_y_latency: got %0d expected %0d", value_y, prev); end
      checks++; if (dut.state !== es) begin failures++; $display("FAIL up_state: got %0d expected %0d", dut.state, es); end
      if (n == 1 && first_y_req >= 0) begin
        checks++; if (dut.position_y !== 12'(first_y_req)) begin failures++; $display("FAIL first_up_y: got %0d expected %0d", dut.position_y, first_y_req); end
      end
      if (mv == 0) break;
      if (n >= 64) begin
        checks++; failures++; $display("FAIL up_bound: got %0d ticks expected apex", n);
        break;
      end
    end
    key_space = 1'b0; key_right = 1'b0; key_left = 1'b0;
  endtask

  task automatic run_fall(input bit hold_space, output int n);
    bit landed;
    state_t es;
    n = 0;
    key_space = hold_space;
    while (1) begin
      key_right = 1'($urandom); key_left = 1'($urandom);
      next_tick();
      mv = (mv + 1 > 16) ? 16 : mv + 1;
      my = (my + mv > GY) ? GY : my + mv;
      mx = model_x(mx, mdr, mdl);
      n++;
      landed = (my == GY);
      if (landed) mv = 0;
      es = landed ? IDLE : FALL;
      checks++; if (dut.position_y !== 12'(my)) begin failures++; $display("FAIL fall_y: got %0d expected %0d", dut.position_y, my); end
      checks++; if (dut.velocity_y !== 8'(mv)) begin failures++; $display("FAIL fall_vel: got %0d expected %0d", dut.velocity_y, mv); end
      checks++; if (dut.position_x !== 12'(mx)) begin failures++; $display("FAIL fall_x: got %0d expected %0d", dut.position_x, mx); end
      checks++; if (dut.state !== es) begin failures++; $display("FAIL fall_state: got %0d expected %0d", dut.state, es); end
      if (landed) break;
      if (n >= 64) begin
        checks++; failures++; $display("FAIL fall_bound: got %0d ticks expected landing", n);
        break;
      end
    end
    key_right = 1'b0; key_left = 1'b0;
    if (hold_space) begin
      cyc();
      checks++; if (dut.state !== CHARGE) begin failures++; $display("FAIL recharge_state: got %0d expected %0d", dut.state, CHARGE); end
      checks++; if (dut.time_passed !== 6'd0) begin failures++; $display("FAIL recharge_tp: got %0d expected 0", dut.time_passed); end
    end
    key_space = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (value_x !== 12'd368) begin failures++; $display("FAIL reset_value_x: got %0d expected 368", value_x); end
    checks++; if (value_y !== 12'd536) begin failures++; $display("FAIL reset_value_y: got %0d expected 536", value_y); end
    checks++; if (dut.cycle_counter !== 24'd0) begin failures++; $display("FAIL reset_counter: got %0d expected 0", dut.cycle_counter); end
    checks++; if (dut.velocity_y !== 8'd0) begin failures++; $display("FAIL reset_vel: got %0d expected 0", dut.velocity_y); end
    checks++; if (dut.time_passed !== 6'd0) begin failures++; $display("FAIL reset_tp: got %0d expected 0", dut.time_passed); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (dut.cycle_counter !== 24'(phase)) begin failures++; $display("FAIL counter_wrap: got %0d expected %0d", dut.cycle_counter, phase); end
    end
  endtask

  task automatic test_jump_default();
    int n;
    do_reset();
    do_charge(10, 1'b0, 1'b0);
    checks++; if (dut.time_passed !== 6'd10) begin failures++; $display("FAIL jump_tp: got %0d expected 10", dut.time_passed); end
    checks++; if (dut.velocity_y !== 8'd14) begin failures++; $display("FAIL jump_vel: got %0d expected 14", dut.velocity_y); end
    run_up(522, n);
    checks++; if (dut.position_y !== 12'd431) begin failures++; $display("FAIL apex_y: got %0d expected 431", dut.position_y); end
    checks++; if (dut.state !== FALL) begin failures++; $display("FAIL apex_state: got %0d expected %0d", dut.state, FALL); end
    run_fall(1'b0, n);
    checks++; if (dut.position_y !== 12'd536) begin failures++; $display("FAIL land_y: got %0d expected 536", dut.position_y); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL land_state: got %0d expected %0d", dut.state, IDLE); end
    cyc();
    checks++; if (value_y !== 12'd536) begin failures++; $display("FAIL land_value_y: got %0d expected 536", value_y); end
  endtask

  task automatic test_horizontal();
    int nl;
    do_reset();
    key_right = 1'b1;
    for (int i = 0; i < 200; i++) begin
      next_tick();
      mx = model_x(mx, 1'b1, 1'b0);
    end
    checks++; if (dut.position_x !== 12'd736) begin failures++; $display("FAIL right_sat: got %0d expected 736", dut.position_x); end
    key_left = 1'b1;
    for (int i = 0; i < 10; i++) next_tick();
    checks++; if (dut.position_x !== 12'd736) begin failures++; $display("FAIL both_keys: got %0d expected 736", dut.position_x); end
    key_right = 1'b0;
    nl = $urandom_range(5, 60);
    for (int i = 0; i < nl; i++) begin
      next_tick();
      mx = model_x(mx, 1'b0, 1'b1);
    end
    checks++; if (dut.position_x !== 12'(mx)) begin failures++; $display("FAIL left_move: got %0d expected %0d", dut.position_x, mx); end
    for (int i = 0; i < 40; i++) begin
      key_right = 1'($urandom); key_left = 1'($urandom);
      next_tick();
      mx = model_x(mx, key_right, key_left);
      checks++; if (dut.position_x !== 12'(mx)) begin failures++; $display("FAIL random_walk: got %0d expected %0d", dut.position_x, mx); end
    end
    key_right = 1'b0; key_left = 1'b0;
    cyc();
    checks++; if (value_x !== 12'(mx)) begin failures++; $display("FAIL value_x_latency: got %0d expected %0d", value_x, mx); end
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    do_charge(100, 1'b0, 1'b0);
    checks++; if (dut.time_passed !== 6'd31) begin failures++; $display("FAIL sat_tp: got %0d expected 31", dut.time_passed); end
    checks++; if (dut.velocity_y !== 8'd35) begin failures++; $display("FAIL sat_vel: got %0d expected 35", dut.velocity_y); end
    run_up(501, n);
    checks++; if (dut.position_y !== 12'd0) begin failures++; $display("FAIL ceiling_y: got %0d expected 0", dut.position_y); end
    checks++; if (dut.state !== FALL) begin failures++; $display("FAIL ceiling_state: got %0d expected %0d", dut.state, FALL); end
    run_fall(1'b0, n);
  endtask

  task automatic test_random_jumps();
    int n;
    do_reset();
    for (int it = 0; it < 5; it++) begin
      do_charge($urandom_range(0, 40), 1'($urandom), 1'($urandom));
      run_up(-1, n);
      run_fall(1'b0, n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    do_charge(0, 1'b1, 1'b0);
    run_up(532, n);
    run_fall(1'b1, n);
  endtask

  task automatic test_reset_mid_jump();
    int n;
    do_reset();
    do_charge(5, 1'b0, 1'b1);
    key_right = 1'b0; key_left = 1'b0;
    next_tick(); next_tick(); next_tick();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    phase = 0;
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL midjump_state: got %0d expected %0d", dut.state, IDLE); end
    checks++; if (dut.position_y !== 12'd536) begin failures++; $display("FAIL midjump_y: got %0d expected 536", dut.position_y); end
    checks++; if (dut.position_x !== 12'd368) begin failures++; $display("FAIL midjump_x: got %0d expected 368", dut.position_x); end
    checks++; if (dut.velocity_y !== 8'd0) begin failures++; $display("FAIL midjump_vel: got %0d expected 0", dut.velocity_y); end
    checks++; if (dut.cycle_counter !== 24'd0) begin failures++; $display("FAIL midjump_counter: got %0d expected 0", dut.cycle_counter); end
    cyc();
    checks++; if (value_y !== 12'd536) begin failures++; $display("FAIL midjump_value_y: got %0d expected 536", value_y); end
    checks++; if (value_x !== 12'd368) begin failures++; $display("FAIL midjump_value_x: got %0d expected 368", value_x); end
    n = 0;
  endtask

  initial begin
    test_reset();
    test_jump_default();
    test_horizontal();
    test_saturate();
    test_random_jumps();
    test_back_to_back();
    test_reset_mid_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
